// File: rtl/xout_accum.sv
// xout_accum: groups an unsigned sample stream into COUNT-sample blocks and emits each block's sum and maximum
module xout_accum #(
    parameter int COUNT = 4,
    parameter int NBITS = 8,
    parameter int SBITS = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NBITS-1:0] XIN,
    input  logic             XIN_VALID,
    output logic             XIN_READY,
    output logic [SBITS-1:0] SUM,
    output logic [NBITS-1:0] MAXV,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic {FILL, STALL} state_t;

    state_t           state, state_n;
    logic [SBITS-1:0] acc, st_sum, blk_sum;
    logic [NBITS-1:0] mx, st_max, blk_max;
    logic [CW-1:0]    cnt;
    logic             take, pop, done, to_out, to_st, from_st;

    assign take    = XIN_VALID && XIN_READY;
    assign pop     = OUT_VALID && OUT_READY;
    assign done    = take && (cnt == LAST);
    assign blk_sum = acc + SBITS'(XIN);
    assign blk_max = (XIN > mx) ? XIN : mx;

    // next state and routing of a finished block: straight to the output slot, or parked in staging
    always_comb begin
        state_n = state;
        to_out  = 1'b0;
        to_st   = 1'b0;
        from_st = 1'b0;
        if (state == FILL) begin
            to_out  = done && (!OUT_VALID || pop);
            to_st   = done && OUT_VALID && !pop;
            state_n = to_st ? STALL : FILL;
        end else begin
            from_st = pop;
            state_n = pop ? FILL : STALL;
        end
    end

    // state register; ready is registered so it stays low through reset and never depends on OUT_READY
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FILL;
            XIN_READY <= 1'b0;
        end else begin
            state     <= state_n;
            XIN_READY <= (state_n == FILL);
        end
    end

    // running sum, max and sample count of the block being filled
    always_ff @(posedge CLK) begin
        if (RST || done) begin
            acc <= '0;
            mx  <= '0;
            cnt <= '0;
        end else if (take) begin
            acc <= blk_sum;
            mx  <= blk_max;
            cnt <= cnt + 1'b1;
        end
    end

    // output slot and staging slot; the output holds while the consumer stalls
    always_ff @(posedge CLK) begin
        if (RST) begin
            SUM       <= '0;
            MAXV      <= '0;
            OUT_VALID <= 1'b0;
            st_sum    <= '0;
            st_max    <= '0;
        end else begin
            if (to_out) begin
                SUM       <= blk_sum;
                MAXV      <= blk_max;
                OUT_VALID <= 1'b1;
            end else if (from_st) begin
                SUM  <= st_sum;
                MAXV <= st_max;
            end else if (pop) begin
                OUT_VALID <= 1'b0;
            end
            if (to_st) begin
                st_sum <= blk_sum;
                st_max <= blk_max;
            end
        end
    end
endmodule

// File: tb/tb_xout_accum.sv
// tb_xout_accum: scoreboard bench for xout_accum with directed scenarios and a long randomized handshake run
module tb_xout_accum;
    localparam int COUNT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  XIN = '0;
    logic        XIN_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic        XIN_READY;
    logic [15:0] SUM;
    logic [7:0]  MAXV;
    logic        OUT_VALID;

    int checks = 0;
    int errors = 0;
    int npops  = 0;

    typedef struct {
        int s;
        int m;
    } res_t;

    res_t exp_q[$];
    int   part[$];
    res_t r, e;
    logic        hold = 1'b0;
    logic [15:0] h_sum;
    logic [7:0]  h_max;

    xout_accum #(.COUNT(COUNT), .NBITS(8), .SBITS(16)) dut (
        .CLK(CLK), .RST(RST), .XIN(XIN), .XIN_VALID(XIN_VALID), .XIN_READY(XIN_READY),
        .SUM(SUM), .MAXV(MAXV), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] xout(input int c, input int a, input int b);
        return 8'((1 + c) * a - b);
    endfunction

    // reference model and monitor: group accepted samples, compare every popped result in order
    always @(negedge CLK) begin
        if (RST) begin
            part.delete();
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", OUT_VALID, 1);
                chk("hold_sum", SUM, h_sum);
                chk("hold_max", MAXV, h_max);
            end
            if (XIN_VALID && XIN_READY) begin
                part.push_back(int'(XIN));
                if (part.size() == COUNT) begin
                    r.s = 0;
                    r.m = 0;
                    foreach (part[i]) begin
                        r.s += part[i];
                        if (part[i] > r.m) r.m = part[i];
                    end
                    exp_q.push_back(r);
                    part.delete();
                end
            end
            if (OUT_VALID && OUT_READY) begin
                npops++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", OUT_VALID, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", SUM, e.s);
                    chk("sb_max", MAXV, e.m);
                end
            end
            hold  = OUT_VALID && !OUT_READY;
            h_sum = SUM;
            h_max = MAXV;
        end
    end

    task automatic feed(input logic [7:0] x);
        XIN_VALID = 1'b1;
        XIN = x;
        for (int t = 0; t <= 200; t++) begin
            @(negedge CLK);
            if (XIN_READY) break;
            if (t == 200) chk("feed_timeout", XIN_READY, 1);
        end
        @(posedge CLK);
        #1;
        XIN_VALID = 1'b0;
    endtask

    initial begin
        int p0;
        int lvl;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_sum", SUM, 0);
        chk("rst_max", MAXV, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_ready", XIN_READY, 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("ready_after_rst", XIN_READY, 1);

        OUT_READY = 1'b1;
        repeat (4) feed(xout(4, 10, 3));
        chk("t1_valid", OUT_VALID, 1);
        chk("t1_sum", SUM, 188);
        chk("t1_max", MAXV, 47);
        @(posedge CLK);
        #1;
        chk("t1_pulse_end", OUT_VALID, 0);

        feed(8'd255); feed(8'd0); feed(8'd1); feed(8'd254);
        chk("t2_sum", SUM, 510);
        chk("t2_max", MAXV, 255);
        repeat (4) feed(8'd0);
        chk("t2_zero_valid", OUT_VALID, 1);
        chk("t2_zero_sum", SUM, 0);
        chk("t2_zero_max", MAXV, 0);
        @(posedge CLK);
        #1;

        OUT_READY = 1'b0;
        p0 = npops;
        repeat (4) feed(8'd1);
        chk("t3_first_valid", OUT_VALID, 1);
        chk("t3_first_sum", SUM, 4);
        repeat (4) feed(8'd1);
        chk("t3_stall_ready", XIN_READY, 0);
        chk("t3_stall_sum", SUM, 4);
        repeat (3) @(posedge CLK);
        #1;
        chk("t3_stall_ready_held", XIN_READY, 0);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("t3_reload_valid", OUT_VALID, 1);
        chk("t3_reload_sum", SUM, 4);
        chk("t3_recover_ready", XIN_READY, 1);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("t3_drained", OUT_VALID, 0);
        chk("t3_pops", npops - p0, 2);

        p0 = npops;
        for (int i = 0; i < 64; i++) begin
            XIN_VALID = 1'b1;
            XIN = 8'($urandom);
            OUT_READY = (i % 4 == 3);
            @(negedge CLK);
            chk("t4_ready", XIN_READY, 1);
            @(posedge CLK);
            #1;
        end
        XIN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("t4_pops", npops - p0, 16);

        OUT_READY = 1'b1;
        feed(8'd100);
        feed(8'd200);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("t5_rst_sum", SUM, 0);
        chk("t5_rst_max", MAXV, 0);
        chk("t5_rst_valid", OUT_VALID, 0);
        chk("t5_rst_ready", XIN_READY, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        p0 = npops;
        repeat (4) feed(8'd9);
        chk("t5_sum", SUM, 36);
        chk("t5_max", MAXV, 9);
        chk("t5_valid", OUT_VALID, 1);
        repeat (3) @(posedge CLK);
        #1;
        chk("t5_pops", npops - p0, 1);

        lvl = 4;
        for (int c = 0; c < 10000; c++) begin
            if (c % 1000 == 0) lvl = int'($urandom_range(1, 8));
            XIN_VALID = ($urandom % 4) != 0;
            XIN = ($urandom % 3 == 0) ? xout(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)))
                                      : 8'($urandom);
            OUT_READY = int'($urandom % 8) < lvl;
            @(posedge CLK);
            #1;
        end
        XIN_VALID = 1'b0;
        OUT_READY = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_valid", OUT_VALID, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
